// File: rtl/instr_encoder.sv
// Instruction encoder: turns op/register/immediate descriptions into 32-bit words and
// writes them to instruction memory. Optional ctrl_echo output: INSTR_ENCODER_CTRL_ECHO_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        prog_clr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        err_illegal,
  output logic [15:0] instr_count,
  output logic        full,
  output logic [5:0]  ctrl_echo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ERR   = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] count_inc;
  logic [31:0] word_q, word_d;
  logic [31:0] word_enc;
  logic        op_legal;
  logic        load_word;

  // Field packing for every legal opcode; anything else is flagged illegal.
  always_comb begin
    op_legal = 1'b1;
    word_enc = '0;
    case (op_sel)
      4'd0:    word_enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    word_enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    word_enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    word_enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    word_enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    word_enc = {6'b001010, rs, rt, imm};
      4'd6:    word_enc = {6'b001000, rs, rt, imm};
      4'd7:    word_enc = {6'b001001, rs, rt, imm};
      4'd8:    word_enc = {6'b000010, target};
      default: op_legal = 1'b0;
    endcase
  end

  assign load_word = (state_q == IDLE) && !prog_clr && in_valid && op_legal;
  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    word_d  = load_word ? word_enc : word_q;
    case (state_q)
      IDLE: begin
        if (prog_clr) begin
          ptr_d   = BASE_ADDR;
          count_d = '0;
        end else if (in_valid) begin
          state_d = op_legal ? WRITE : ERR;
        end
      end
      WRITE: begin
        // The write itself happens this cycle regardless; a clear only redirects the bookkeeping.
        if (prog_clr) begin
          ptr_d   = BASE_ADDR;
          count_d = '0;
          state_d = IDLE;
        end else begin
          ptr_d   = ptr_q + 32'd4;
          count_d = count_inc;
          state_d = (count_inc == DEPTH_W) ? FULL : IDLE;
        end
      end
      ERR, FULL: begin
        if (prog_clr) begin
          ptr_d   = BASE_ADDR;
          count_d = '0;
          state_d = IDLE;
        end else if (state_q == ERR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  // All outputs come straight from registers or a decode of the state register.
  assign in_ready    = (state_q == IDLE);
  assign mem_we      = (state_q == WRITE);
  assign err_illegal = (state_q == ERR);
  assign full        = (state_q == FULL);
  assign mem_addr    = ptr_q;
  assign mem_wdata   = word_q;
  assign instr_count = count_q;

`ifdef INSTR_ENCODER_CTRL_ECHO_EN
  logic [5:0] ctrl_q, ctrl_d, ctrl_enc;

  // {RegDst, ALUSrc, RegWrite, Jump, ALUOp[1:0]} a decoder would derive from the word.
  always_comb begin
    ctrl_enc = '0;
    case (op_sel)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: ctrl_enc = 6'b101010;
      4'd5:    ctrl_enc = 6'b011000;
      4'd6:    ctrl_enc = 6'b011001;
      4'd7:    ctrl_enc = 6'b011011;
      4'd8:    ctrl_enc = 6'b000100;
      default: ctrl_enc = 6'b000000;
    endcase
  end

  assign ctrl_d = load_word ? ctrl_enc : ctrl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl_echo = ctrl_q;
`else
  assign ctrl_echo = 6'b000000;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against an arithmetic reference model.
module tb_instr_encoder;

  localparam int          TB_DEPTH = 16;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [31:0] B_BASE   = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset, in_valid, prog_clr;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        in_ready, mem_we, err_illegal, full;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] instr_count;
  logic [5:0]  ctrl_echo;

  logic        b_valid, b_clr;
  logic        b_ready, b_we, b_err, b_full;
  logic [31:0] b_addr, b_wdata;
  logic [15:0] b_count;
  logic [5:0]  b_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_ptr, m_word;
  int          m_count;
  logic [5:0]  m_ctrl;
  bit          m_full;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(TB_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .prog_clr(prog_clr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err_illegal(err_illegal), .instr_count(instr_count), .full(full), .ctrl_echo(ctrl_echo)
  );

  instr_encoder #(.BASE_ADDR(B_BASE), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .prog_clr(b_clr), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .err_illegal(b_err), .instr_count(b_count), .full(b_full), .ctrl_echo(b_ctrl)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word built from the field layout with plain shifts-as-multiplication.
  function automatic logic [31:0] ref_word(input int op, input int a, input int b, input int c,
                                           input int i, input int t);
    longint w;
    int f;
    case (op)
      0: f = 32; 1: f = 34; 2: f = 36; 3: f = 37; 4: f = 42;
      5: f = 10; 6: f = 8;  7: f = 9;  default: f = 2;
    endcase
    if (op <= 4)      w = longint'(a) * 2097152 + longint'(b) * 65536 + longint'(c) * 2048 + f;
    else if (op <= 7) w = longint'(f) * 67108864 + longint'(a) * 2097152 + longint'(b) * 65536 + i;
    else              w = longint'(2) * 67108864 + t;
    return w[31:0];
  endfunction

  function automatic logic [5:0] ref_ctrl(input int op);
`ifdef INSTR_ENCODER_CTRL_ECHO_EN
    if (op <= 4) return 6'b101010;
    if (op == 5) return 6'b011000;
    if (op == 6) return 6'b011001;
    if (op == 7) return 6'b011011;
    return 6'b000100;
`else
    return 6'b000000;
`endif
  endfunction

  function automatic logic [89:0] mk(input logic rdy, input logic we, input logic er, input logic fu,
                                     input logic [5:0] c, input int cnt, input logic [31:0] a,
                                     input logic [31:0] w);
    return {rdy, we, er, fu, c, 16'(cnt), a, w};
  endfunction

  function automatic logic [89:0] obs();
    return {in_ready, mem_we, err_illegal, full, ctrl_echo, instr_count, mem_addr, mem_wdata};
  endfunction

  function automatic logic [89:0] idle_exp();
    return mk(!m_full, 1'b0, 1'b0, m_full, m_ctrl, m_count, m_ptr, m_word);
  endfunction

  task automatic model_reset();
    m_ptr = BASE; m_word = '0; m_count = 0; m_ctrl = '0; m_full = 0;
  endtask

  // One request through the encoder; optional clear or reset during the write cycle.
  task automatic run_op(input string name, input logic [3:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c, input logic [15:0] i,
                        input logic [25:0] t, input bit clr_w, input bit rst_w);
    logic [31:0] w;
    logic [5:0]  cc;
    logic [89:0] e;
    op_sel = op; rs = a; rt = b; rd = c; imm = i; target = t; in_valid = 1'b1;
    e = idle_exp();
    n_tests++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL %s pre: got %h want %h", name, obs(), e);
    end
    step();
    in_valid = 1'b0;
    if (op <= 4'd8) begin
      w  = ref_word(int'(op), int'(a), int'(b), int'(c), int'(i), int'(t));
      cc = ref_ctrl(int'(op));
      e  = mk(1'b0, 1'b1, 1'b0, 1'b0, cc, m_count, m_ptr, w);
      n_tests++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL %s write: got %h want %h", name, obs(), e);
      end
      $display("[TB] %s op=%0d addr=%h word=%h", name, op, m_ptr, w);
      prog_clr = clr_w; reset = rst_w;
      step();
      prog_clr = 1'b0; reset = 1'b0;
      if (rst_w) model_reset();
      else begin
        m_word = w; m_ctrl = cc;
        if (clr_w) begin
          m_ptr = BASE; m_count = 0;
        end else begin
          m_ptr = m_ptr + 32'd4; m_count++; m_full = (m_count == TB_DEPTH);
        end
      end
    end else begin
      e = mk(1'b0, 1'b0, 1'b1, 1'b0, m_ctrl, m_count, m_ptr, m_word);
      n_tests++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL %s err: got %h want %h", name, obs(), e);
      end
      $display("[TB] %s op=%0d rejected", name, op);
      step();
    end
    e = idle_exp();
    n_tests++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL %s post: got %h want %h", name, obs(), e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; prog_clr = 1'b1; op_sel = 4'd0;
    repeat (3) step();
    model_reset();
    n_tests++;
    if (obs() !== idle_exp()) begin
      n_fail++; $display("FAIL reset: got %h want %h", obs(), idle_exp());
    end
    n_tests++;
    if ({b_ready, b_we, b_full, b_count, b_addr, b_wdata} !== {1'b1, 1'b0, 1'b0, 16'd0, B_BASE, 32'd0}) begin
      n_fail++; $display("FAIL reset_b: got addr %h count %0d we %b", b_addr, b_count, b_we);
    end
    reset = 1'b0; in_valid = 1'b0; prog_clr = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [5:0] c1, c2;
`ifdef INSTR_ENCODER_CTRL_ECHO_EN
    c1 = 6'b011001; c2 = 6'b000100;
`else
    c1 = 6'b000000; c2 = 6'b000000;
`endif
    run_op("add", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0, 0);
    n_tests++;
    if (mem_wdata !== 32'h0022_1820 || instr_count !== 16'd1) begin
      n_fail++; $display("FAIL add_word: got %h cnt %0d want 00221820 cnt 1", mem_wdata, instr_count);
    end
    run_op("addi", 4'd6, 5'd0, 5'd5, 5'd0, 16'h0007, 26'h0, 0, 0);
    n_tests++;
    if (mem_wdata !== 32'h2005_0007 || ctrl_echo !== c1) begin
      n_fail++; $display("FAIL addi_word: got %h/%b want 20050007/%b", mem_wdata, ctrl_echo, c1);
    end
    run_op("j", 4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010, 0, 0);
    n_tests++;
    if (mem_wdata !== 32'h0800_0010 || ctrl_echo !== c2 || mem_addr !== 32'd12) begin
      n_fail++; $display("FAIL j_word: got %h/%b addr %h want 08000010/%b addr 0000000c",
                         mem_wdata, ctrl_echo, mem_addr, c2);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] a0;
    a0 = mem_addr;
    run_op("illegal", 4'd12, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FF_FFFF, 0, 0);
    n_tests++;
    if (mem_addr !== a0) begin
      n_fail++; $display("FAIL illegal_addr: got %h want %h", mem_addr, a0);
    end
    run_op("after_illegal", 4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int writes;
    logic [31:0] addrs [2];
    writes = 0;
    op_sel = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3;
    b_valid = 1'b1;
    repeat (10) begin
      step();
      if (b_we) begin
        if (writes < 2) addrs[writes] = b_addr;
        writes++;
      end
    end
    n_tests++;
    if (writes !== 2 || addrs[0] !== B_BASE || addrs[1] !== 32'h0) begin
      n_fail++; $display("FAIL b2b_writes: got %0d writes (%h,%h) want 2 (fffffffc,00000000)",
                         writes, addrs[0], addrs[1]);
    end
    n_tests++;
    if ({b_full, b_ready, b_count} !== {1'b1, 1'b0, 16'd2}) begin
      n_fail++; $display("FAIL b2b_full: got full %b ready %b cnt %0d want 1 0 2", b_full, b_ready, b_count);
    end
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    n_tests++;
    if ({b_full, b_ready, b_count, b_addr} !== {1'b0, 1'b1, 16'd0, B_BASE}) begin
      n_fail++; $display("FAIL b2b_clr: got full %b ready %b cnt %0d addr %h", b_full, b_ready, b_count, b_addr);
    end
    step();
    b_valid = 1'b0;
    n_tests++;
    if ({b_we, b_addr, b_wdata} !== {1'b1, B_BASE, 32'h0022_1820}) begin
      n_fail++; $display("FAIL b2b_rewrite: got we %b addr %h data %h", b_we, b_addr, b_wdata);
    end
    $display("[TB] b2b writes=%0d then rewrite at %h", writes, b_addr);
    step();
  endtask

  task automatic test_clr_in_write();
    run_op("pre_clr", 4'd3, 5'd9, 5'd8, 5'd7, 16'h0, 26'h0, 0, 0);
    run_op("clr_in_write", 4'd5, 5'd0, 5'd31, 5'd0, 16'h1234, 26'h0, 1, 0);
    n_tests++;
    if (instr_count !== 16'd0 || mem_addr !== BASE) begin
      n_fail++; $display("FAIL clr_in_write: got cnt %0d addr %h want 0 %h", instr_count, mem_addr, BASE);
    end
    run_op("after_clr", 4'd7, 5'd2, 5'd3, 5'd0, 16'h8001, 26'h0, 0, 0);
  endtask

  task automatic test_reset_in_write();
    run_op("rst_in_write", 4'd2, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 0, 1);
    step();
    n_tests++;
    if (obs() !== mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 0, BASE, 32'd0)) begin
      n_fail++; $display("FAIL rst_in_write_hold: got %h", obs());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if (m_full) begin
        in_valid = 1'b1; op_sel = 4'($urandom_range(0, 8));
        step();
        n_tests++;
        if (obs() !== idle_exp()) begin
          n_fail++; $display("FAIL rnd_full_hold: got %h want %h", obs(), idle_exp());
        end
        prog_clr = 1'b1;
        step();
        in_valid = 1'b0; prog_clr = 1'b0;
        m_ptr = BASE; m_count = 0; m_full = 0;
        n_tests++;
        if (obs() !== idle_exp()) begin
          n_fail++; $display("FAIL rnd_full_clr: got %h want %h", obs(), idle_exp());
        end
      end
      repeat ($urandom_range(0, 2)) begin
        prog_clr = ($urandom_range(0, 19) == 0);
        in_valid = prog_clr & 1'($urandom);
        step();
        if (prog_clr) begin
          m_ptr = BASE; m_count = 0;
        end
        prog_clr = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (obs() !== idle_exp()) begin
          n_fail++; $display("FAIL rnd_gap: got %h want %h", obs(), idle_exp());
        end
      end
      run_op("rnd", 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 26'($urandom), ($urandom_range(0, 15) == 0), 0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; prog_clr = 1'b0; b_valid = 1'b0; b_clr = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
    model_reset();
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_clr_in_write();
    test_reset_in_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
